// File: rtl/alu_pkt_driver_if.sv
// alu_pkt_driver_if: packet, ALU and tagged-result signals of alu_pkt_driver.
// ALU_PKT_DRIVER_CHECK_EN adds the golden-model mismatch signals err_o/err_cnt_o.
interface alu_pkt_driver_if #(
   parameter int DATA_W  = 8,
   parameter int OP_W    = 3,
   parameter int SLOT_W  = 24,
   parameter int NUM_OPS = 100,
   parameter int RES_W   = 16,
   parameter int IDX_W   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
);
   logic                      pkt_valid_i;
   logic                      pkt_ready_o;
   logic [NUM_OPS*SLOT_W-1:0] pkt_data_i;
   logic [DATA_W-1:0]         alu_a_o;
   logic [DATA_W-1:0]         alu_b_o;
   logic [OP_W-1:0]           alu_op_o;
   logic                      alu_start_o;
   logic                      alu_done_i;
   logic [RES_W-1:0]          alu_result_i;
   logic                      res_valid_o;
   logic [RES_W-1:0]          res_data_o;
   logic [IDX_W-1:0]          res_idx_o;
   logic                      timeout_o;
   logic                      pkt_done_o;
   logic                      busy_o;
`ifdef ALU_PKT_DRIVER_CHECK_EN
   logic                      err_o;
   logic [15:0]               err_cnt_o;
`endif
   modport master (
      input  pkt_valid_i, pkt_data_i, alu_done_i, alu_result_i,
      output pkt_ready_o, alu_a_o, alu_b_o, alu_op_o, alu_start_o,
             res_valid_o, res_data_o, res_idx_o, timeout_o, pkt_done_o, busy_o
`ifdef ALU_PKT_DRIVER_CHECK_EN
      , output err_o, err_cnt_o
`endif
   );
   modport slave (
      output pkt_valid_i, pkt_data_i, alu_done_i, alu_result_i,
      input  pkt_ready_o, alu_a_o, alu_b_o, alu_op_o, alu_start_o,
             res_valid_o, res_data_o, res_idx_o, timeout_o, pkt_done_o, busy_o
`ifdef ALU_PKT_DRIVER_CHECK_EN
      , input err_o, err_cnt_o
`endif
   );
endinterface

// File: rtl/alu_pkt_driver.sv
// alu_pkt_driver: issues each slot of a packet to the ALU over start/done and returns tagged results.
// ALU_PKT_DRIVER_CHECK_EN adds an internal golden model with err_o/err_cnt_o.
module alu_pkt_driver #(
   parameter int DATA_W   = 8,
   parameter int OP_W     = 3,
   parameter int SLOT_W   = 24,
   parameter int NUM_OPS  = 100,
   parameter int RES_W    = 16,
   parameter int MAX_WAIT = 64
) (
   input logic           clk_i,
   input logic           reset_i,
   alu_pkt_driver_if.master bus
);
   localparam int PKT_W = NUM_OPS * SLOT_W;
   localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
   localparam int WC_W  = $clog2(MAX_WAIT + 1);
   typedef enum logic [1:0] {IDLE, LOAD, WAIT, ADV} state_t;
   state_t           state, state_nx;
   logic [PKT_W-1:0] sh;
   logic [IDX_W-1:0] slot;
   logic [WC_W-1:0]  wcnt;
   logic [OP_W-1:0]  cur_op;
   logic             issue, last, expire;
   assign cur_op = sh[OP_W-1:0];
   assign issue  = (cur_op != '0) && (cur_op <= OP_W'(4));
   assign last   = slot == IDX_W'(NUM_OPS - 1);
   assign expire = wcnt == WC_W'(MAX_WAIT - 1);
   always_ff @(posedge clk_i or negedge reset_i)
      if (!reset_i) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = bus.pkt_valid_i ? LOAD : IDLE;
         LOAD:    state_nx = issue ? WAIT : ADV;
         WAIT:    state_nx = (bus.alu_done_i || expire) ? ADV : WAIT;
         default: state_nx = last ? IDLE : LOAD;
      endcase
   end
   always_comb begin
      bus.pkt_ready_o = state == IDLE;
      bus.busy_o      = state != IDLE;
   end
   // Slot fields always come from the low end; ADV shifts the next slot down.
   always_ff @(posedge clk_i or negedge reset_i)
      if (!reset_i) begin
         sh              <= '0;
         slot            <= '0;
         wcnt            <= '0;
         bus.alu_a_o     <= '0;
         bus.alu_b_o     <= '0;
         bus.alu_op_o    <= '0;
         bus.alu_start_o <= 1'b0;
         bus.res_valid_o <= 1'b0;
         bus.res_data_o  <= '0;
         bus.res_idx_o   <= '0;
         bus.timeout_o   <= 1'b0;
         bus.pkt_done_o  <= 1'b0;
      end else begin
         bus.res_valid_o <= 1'b0;
         bus.timeout_o   <= 1'b0;
         bus.pkt_done_o  <= 1'b0;
         case (state)
            IDLE: if (bus.pkt_valid_i) begin
               sh   <= bus.pkt_data_i;
               slot <= '0;
            end
            LOAD: begin
               bus.alu_op_o    <= cur_op;
               bus.alu_a_o     <= sh[8 +: DATA_W];
               bus.alu_b_o     <= sh[8+DATA_W +: DATA_W];
               bus.alu_start_o <= issue;
               wcnt            <= '0;
            end
            WAIT: if (bus.alu_done_i) begin
               bus.alu_start_o <= 1'b0;
               bus.res_valid_o <= 1'b1;
               bus.res_data_o  <= bus.alu_result_i;
               bus.res_idx_o   <= slot;
            end else if (expire) begin
               bus.alu_start_o <= 1'b0;
               bus.timeout_o   <= 1'b1;
            end else wcnt <= wcnt + WC_W'(1);
            default: begin
               sh             <= sh >> SLOT_W;
               bus.pkt_done_o <= last;
               if (!last) slot <= slot + IDX_W'(1);
            end
         endcase
      end
`ifdef ALU_PKT_DRIVER_CHECK_EN
   logic [RES_W-1:0] gold;
   logic             mism;
   always_comb begin
      gold = (bus.alu_op_o == OP_W'(1)) ? RES_W'(bus.alu_a_o) + RES_W'(bus.alu_b_o) :
             (bus.alu_op_o == OP_W'(2)) ? RES_W'(bus.alu_a_o & bus.alu_b_o) :
             (bus.alu_op_o == OP_W'(3)) ? RES_W'(bus.alu_a_o ^ bus.alu_b_o) :
                                          RES_W'(bus.alu_a_o) * RES_W'(bus.alu_b_o);
      mism = (state == WAIT) && bus.alu_done_i && (bus.alu_result_i != gold);
   end
   always_ff @(posedge clk_i or negedge reset_i)
      if (!reset_i) begin
         bus.err_o     <= 1'b0;
         bus.err_cnt_o <= '0;
      end else begin
         bus.err_o <= mism;
         if (mism && bus.err_cnt_o != '1) bus.err_cnt_o <= bus.err_cnt_o + 16'd1;
      end
`endif
endmodule

// File: tb/tb_alu_pkt_driver.sv
// tb_alu_pkt_driver: scoreboard bench for alu_pkt_driver with a behavioural ALU and event queue.
module tb_alu_pkt_driver;
   localparam int DATA_W = 8, OP_W = 3, SLOT_W = 24, NUM_OPS = 4, RES_W = 16, MAX_WAIT = 64;
   localparam int PKT_W = NUM_OPS * SLOT_W;
`ifdef ALU_PKT_DRIVER_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   typedef struct {int kind; int idx; logic [RES_W-1:0] data; bit corrupt;} ev_t;
   typedef struct {int lat; bit corrupt;} plan_t;
   logic clk_i = 1'b0;
   logic reset_i = 1'b0;
   int   total = 0, bad = 0;
   ev_t   exp_q[$];
   plan_t plan_q[$];
   int    p_lat[NUM_OPS];
   bit    p_bad[NUM_OPS];
   alu_pkt_driver_if #(.DATA_W(DATA_W), .OP_W(OP_W), .SLOT_W(SLOT_W), .NUM_OPS(NUM_OPS), .RES_W(RES_W)) bus();
   alu_pkt_driver #(.DATA_W(DATA_W), .OP_W(OP_W), .SLOT_W(SLOT_W), .NUM_OPS(NUM_OPS), .RES_W(RES_W),
                    .MAX_WAIT(MAX_WAIT)) dut (.clk_i(clk_i), .reset_i(reset_i), .bus(bus));
   always #5 clk_i = ~clk_i;

   function automatic logic [RES_W-1:0] alu_ref(int op, int a, int b);
      case (op)
         1:       return RES_W'(a + b);
         2:       return RES_W'(a & b);
         3:       return RES_W'(a ^ b);
         default: return RES_W'(a * b);
      endcase
   endfunction

   function automatic logic [SLOT_W-1:0] slot(int op, int a, int b);
      return SLOT_W'((b << 16) | (a << 8) | op);
   endfunction

   task automatic chk(string name, longint act, longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Expected events come from the packet contents and the ALU plan, never from the DUT.
   task automatic send_pkt(input logic [PKT_W-1:0] d);
      int n = 0;
      for (int k = 0; k < NUM_OPS; k++) begin
         int op = int'(d[k*SLOT_W +: OP_W]);
         int a  = int'(d[k*SLOT_W+8 +: DATA_W]);
         int b  = int'(d[k*SLOT_W+16 +: DATA_W]);
         if (op >= 1 && op <= 4) begin
            plan_q.push_back(plan_t'{p_lat[k], p_bad[k]});
            if (p_lat[k] < 0) exp_q.push_back(ev_t'{1, k, '0, 1'b0});
            else exp_q.push_back(ev_t'{0, k, alu_ref(op, a, b) ^ RES_W'(p_bad[k]), p_bad[k]});
         end
      end
      exp_q.push_back(ev_t'{2, 0, '0, 1'b0});
      bus.pkt_data_i  = d;
      bus.pkt_valid_i = 1'b1;
      while (!bus.pkt_ready_o && n < 2000) begin
         @(negedge clk_i);
         n++;
      end
      chk("accept_bound", longint'(n < 2000), 1);
      @(posedge clk_i);
      #1 bus.pkt_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(negedge clk_i);
         n++;
      end
      chk("drain_pending", exp_q.size(), 0);
   endtask

   // Behavioural ALU: answers each start after the planned latency, or never (lat < 0).
   initial begin
      plan_t p;
      int n;
      bus.alu_done_i   = 1'b0;
      bus.alu_result_i = '0;
      forever begin
         @(negedge clk_i);
         if (bus.alu_start_o) begin
            chk("planned_start", longint'(plan_q.size() != 0), 1);
            p = (plan_q.size() != 0) ? plan_q.pop_front() : plan_t'{1, 1'b0};
            if (p.lat > 0) begin
               repeat (p.lat - 1) @(negedge clk_i);
               bus.alu_result_i = alu_ref(int'(bus.alu_op_o), int'(bus.alu_a_o), int'(bus.alu_b_o))
                                  ^ RES_W'(p.corrupt);
               bus.alu_done_i = 1'b1;
               @(negedge clk_i);
               bus.alu_done_i = 1'b0;
            end
            n = 0;
            while (bus.alu_start_o && n < 200) begin
               @(negedge clk_i);
               n++;
            end
         end
      end
   end

   // Monitor: pops one expected event per result, timeout or packet-done strobe.
   initial begin
      ev_t  e;
      int   kind, hi, last_run;
      logic prev_start;
      logic [2*DATA_W+OP_W-1:0] prev_ops;
      hi = 0; last_run = 0; prev_start = 1'b0; prev_ops = '0;
      forever begin
         @(negedge clk_i);
         if (bus.alu_start_o) hi++;
         else begin
            if (hi != 0) last_run = hi;
            hi = 0;
         end
         if (bus.alu_start_o && prev_start)
            chk("ops_stable", {bus.alu_op_o, bus.alu_a_o, bus.alu_b_o}, prev_ops);
         if (bus.res_valid_o && bus.timeout_o) chk("valid_timeout_excl", 1, 0);
         if (bus.res_valid_o || bus.timeout_o || bus.pkt_done_o) begin
            kind = bus.res_valid_o ? 0 : bus.timeout_o ? 1 : 2;
            if (exp_q.size() == 0) chk("unexpected_event", kind, -1);
            else begin
               e = exp_q.pop_front();
               chk("event_kind", kind, e.kind);
               if (kind == 0) begin
                  chk("res_idx", bus.res_idx_o, e.idx);
                  chk("res_data", bus.res_data_o, e.data);
                  chk("start_low_at_res", bus.alu_start_o, 0);
               end
               if (kind == 1) chk("timeout_len", last_run, MAX_WAIT);
`ifdef ALU_PKT_DRIVER_CHECK_EN
               chk("err_pulse", bus.err_o, longint'(kind == 0 && e.corrupt));
`endif
            end
         end
`ifdef ALU_PKT_DRIVER_CHECK_EN
         else if (bus.err_o) chk("err_without_res", 1, 0);
`endif
         prev_start = bus.alu_start_o;
         prev_ops   = {bus.alu_op_o, bus.alu_a_o, bus.alu_b_o};
      end
   end

   initial begin
      logic [PKT_W-1:0] d2, d;
      int n;
      d2 = {slot(4, 8'hFF, 8'hFF), slot(3, 8'hAA, 8'h55), slot(2, 8'hF0, 8'h3C), slot(1, 8'h12, 8'h34)};
      bus.pkt_valid_i = 1'b1;
      bus.pkt_data_i  = d2;
      for (int i = 0; i < NUM_OPS; i++) p_bad[i] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         chk("reset_outputs", {bus.pkt_ready_o, bus.busy_o, bus.alu_start_o, bus.res_valid_o,
                               bus.timeout_o, bus.pkt_done_o}, 6'b100000);
      end
      reset_i = 1'b1;
      p_lat = '{1, 1, 1, 3};
      send_pkt(d2);
      drain();
      p_lat = '{1, 1, 1, 1};
      send_pkt({slot(0, 1, 2), slot(6, 3, 4), slot(0, 5, 6), slot(1, 8'h20, 8'h22)});
      drain();
      p_lat = '{2, -1, 1, 4};
      send_pkt({slot(4, 8'h11, 8'h13), slot(3, 8'h0F, 8'hF0), slot(1, 8'h80, 8'h80), slot(2, 8'h5A, 8'hC3)});
      drain();
      for (int pk = 0; pk < 30; pk++) begin
         d = '0;
         for (int k = 0; k < NUM_OPS; k++) begin
            d[k*SLOT_W +: SLOT_W] = slot($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
            p_lat[k] = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(1, 5));
         end
         send_pkt(d);
      end
      drain();
      p_lat = '{1, 1, -1, 1};
      send_pkt(d2);
      n = 0;
      while (!(bus.alu_start_o && bus.alu_op_o == 3'd3) && n < 500) begin
         @(negedge clk_i);
         n++;
      end
      chk("reach_wait_slot2", longint'(n < 500), 1);
      repeat (5) @(negedge clk_i);
      #2 reset_i = 1'b0;
      #1 chk("midreset_outputs", {bus.pkt_ready_o, bus.busy_o, bus.alu_start_o, bus.res_valid_o,
                                  bus.timeout_o, bus.pkt_done_o}, 6'b100000);
      chk("midreset_pending", exp_q.size(), 3);
      exp_q.delete();
      plan_q.delete();
      repeat (3) @(negedge clk_i);
      reset_i = 1'b1;
      p_lat = '{1, 1, 1, 3};
      p_bad[0] = CHK;
      send_pkt(d2);
      drain();
`ifdef ALU_PKT_DRIVER_CHECK_EN
      chk("err_cnt", bus.err_cnt_o, 1);
`endif
      repeat (5) @(negedge clk_i);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
